// File: rtl/ifu_pkg.sv
// Shared fetch-unit types and constants: NOP encoding, reset PC default, PC step,
// and the {pc, instr} record carried through the fetch buffer.
package ifu_pkg;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/ifu_if.sv
// Instruction SRAM read port: request/ready handshake, data returns exactly one cycle
// after an accepted request. Master is the fetch unit, slave is the SRAM.
interface ifu_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous fetch buffer, registered count; head visible combinationally (0-cycle read).
// Flush beats push; push and pop in the same cycle are allowed; caller guarantees no overflow.
module ifu_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             full;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full && !pop_i && !flush_i));
endmodule

// File: rtl/ifu.sv
// Instruction fetch: PC + credit-limited SRAM reads into a small buffer; req->decode in 2 cycles,
// 1 instr/cycle sustained. ls_hold_i freezes delivery (fetch stops when credits run out); jump_i flushes.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         jump_i,
    input  logic [31:0]  jump_addr_i,
    input  logic         ls_hold_i,
    ifu_if.master        imem,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o,
    output logic         instr_valid_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;
    logic          empty, pop, push, accept, rsp;
    fetch_t        head, push_dat;

    // A same-cycle pop frees a slot, so credits count it to keep the stream at full rate.
    assign pop        = !empty && !ls_hold_i && !jump_i;
    assign used       = {1'b0, fifo_count} + {1'b0, out_q} - (CW+1)'(pop);
    assign imem.req   = !rst && !jump_i && (used < (CW+1)'(FIFO_DEPTH));
    assign imem.addr  = pc_q;
    assign accept     = imem.req && imem.ready;
    // rvalid with nothing in flight (e.g. straight after reset) is stale and ignored.
    assign rsp        = imem.rvalid && (out_q != '0);
    assign push       = rsp && (drop_q == '0) && !jump_i;
    assign push_dat   = '{pc: req_pc_q, instr: imem.rdata};

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        out_d    = out_q - CW'(rsp) + CW'(accept);
        if (accept) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
        end
        if (jump_i) begin
            pc_d   = align_word(jump_addr_i);
            drop_d = out_d;
        end else if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump_i),
        .push_i  (push),
        .din_i   (push_dat),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign instr_valid_o = pop;
    assign instr_o       = pop ? head.instr : NOP;
    assign pc_o          = empty ? pc_q : head.pc;
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: SRAM model returns mem[addr>>2] = addr>>2, scoreboard of expected {pc, instr}.
module tb_ifu;
    import ifu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, jump_a, hold_a, ready_a;
    logic [31:0] jaddr_a;
    logic [31:0] instr_a, pc_a;
    logic        vld_a;
    logic        rst_b, inj_b;
    logic [31:0] instr_b, pc_b;
    logic        vld_b;
    logic        a_rv, b_rv;
    logic [31:0] a_rd, b_rd;

    ifu_if ifa();
    ifu_if ifb();

    ifu #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst_a), .jump_i(jump_a), .jump_addr_i(jaddr_a), .ls_hold_i(hold_a),
        .imem(ifa), .instr_o(instr_a), .pc_o(pc_a), .instr_valid_o(vld_a));

    ifu #(.RESET_PC(32'h0000_0080), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst_b), .jump_i(1'b0), .jump_addr_i(32'h0), .ls_hold_i(1'b0),
        .imem(ifb), .instr_o(instr_b), .pc_o(pc_b), .instr_valid_o(vld_b));

    assign ifa.ready  = ready_a;
    assign ifa.rvalid = a_rv;
    assign ifa.rdata  = a_rd;
    always @(posedge clk) begin
        a_rv <= ifa.req && ifa.ready;
        a_rd <= {2'b00, ifa.addr[31:2]};
    end

    assign ifb.ready  = 1'b1;
    assign ifb.rvalid = b_rv | inj_b;
    assign ifb.rdata  = inj_b ? 32'hDEAD_BEEF : b_rd;
    always @(posedge clk) begin
        b_rv <= ifb.req && ifb.ready;
        b_rd <= {2'b00, ifb.addr[31:2]};
    end

    int          checks = 0;
    int          errors = 0;
    int          n_deliv = 0;
    fetch_t      sb_q[$];
    logic [31:0] sb_tail;
    logic        prev_stall;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_fill();
        while (sb_q.size() < 8) begin
            sb_q.push_back('{pc: sb_tail, instr: {2'b00, sb_tail[31:2]}});
            sb_tail = sb_tail + PC_STEP;
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        sb_tail = start;
        sb_fill();
    endtask

    task automatic monitor();
        fetch_t e;
        if (prev_stall && !jump_a) begin
            chk("req_held", 32'(ifa.req), 32'd1);
            chk("addr_held", ifa.addr, prev_addr);
        end
        if (vld_a) begin
            e = sb_q.pop_front();
            chk("deliv_pc", pc_a, e.pc);
            chk("deliv_instr", instr_a, e.instr);
            n_deliv++;
            sb_fill();
        end else begin
            chk("idle_nop", instr_a, NOP);
        end
        prev_stall = ifa.req && !ifa.ready;
        prev_addr  = ifa.addr;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    // Leaves the bench at the negedge of the first valid cycle when ok=1.
    task automatic wait_vld(input bit which_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            half();
            if (which_b ? vld_b : vld_a) ok = 1'b1;
            else fin();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen_wrap;
        int n0;
        rst_a = 1'b1; jump_a = 1'b0; jaddr_a = '0; hold_a = 1'b0; ready_a = 1'b1;
        rst_b = 1'b1; inj_b = 1'b0; prev_stall = 1'b0; prev_addr = '0;
        sb_restart(32'h0);
        @(posedge clk); #1;

        half();
        chk("rst_req", 32'(ifa.req), 32'd0);
        chk("rst_vld", 32'(vld_a), 32'd0);
        chk("rst_instr", instr_a, NOP);
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_pc_b", pc_b, 32'h80);
        chk("rst_vld_b", 32'(vld_b), 32'd0);
        fin();
        rst_a = 1'b0;

        // Cold start: first valid in cycle 2, then one per cycle
        half(); chk("c0_req", 32'(ifa.req), 32'd1); chk("c0_addr", ifa.addr, 32'h0);
        chk("c0_vld", 32'(vld_a), 32'd0); fin();
        half(); chk("c1_addr", ifa.addr, 32'h4); chk("c1_vld", 32'(vld_a), 32'd0); fin();
        half(); chk("c2_vld", 32'(vld_a), 32'd1); chk("c2_pc", pc_a, 32'h0); fin();
        for (int i = 0; i < 6; i++) begin
            half(); chk("stream_vld", 32'(vld_a), 32'd1); fin();
        end

        // Load/store hold: NOP, no delivery, fetch stops once buffer is full
        hold_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("hold_vld", 32'(vld_a), 32'd0);
            chk("hold_instr", instr_a, NOP);
            chk("hold_req", 32'(ifa.req), 32'd0);
            fin();
        end
        hold_a = 1'b0;
        half(); chk("release_vld", 32'(vld_a), 32'd1); fin();
        repeat (4) step();

        // Jump while a response is landing and the buffer holds old instructions
        jump_a = 1'b1; jaddr_a = 32'h100; sb_restart(32'h100);
        half();
        chk("j1_rvalid", 32'(ifa.rvalid), 32'd1);
        chk("j1_vld", 32'(vld_a), 32'd0);
        chk("j1_req", 32'(ifa.req), 32'd0);
        fin();
        jump_a = 1'b0;
        half(); chk("j1_next_req", 32'(ifa.req), 32'd1); chk("j1_next_addr", ifa.addr, 32'h100); fin();
        wait_vld(1'b0, 2, ok);
        chk("j1_latency", 32'(ok), 32'd1);
        if (ok) begin chk("j1_pc", pc_a, 32'h100); fin(); end
        repeat (3) step();

        // Jump wins over hold with a full buffer; target low bits forced to zero
        hold_a = 1'b1;
        repeat (2) step();
        jump_a = 1'b1; jaddr_a = 32'h203; sb_restart(32'h200);
        half(); chk("j2_vld", 32'(vld_a), 32'd0); chk("j2_req", 32'(ifa.req), 32'd0); fin();
        jump_a = 1'b0; hold_a = 1'b0;
        half(); chk("j2_addr", ifa.addr, 32'h200); fin();
        wait_vld(1'b0, 2, ok);
        chk("j2_latency", 32'(ok), 32'd1);
        if (ok) begin chk("j2_pc", pc_a, 32'h200); chk("j2_instr", instr_a, 32'h80); fin(); end
        repeat (3) step();

        // Back-to-back jumps: only the last target survives
        jump_a = 1'b1; jaddr_a = 32'h300;
        half(); chk("bb0_req", 32'(ifa.req), 32'd0); fin();
        jaddr_a = 32'h400; sb_restart(32'h400);
        half(); chk("bb1_req", 32'(ifa.req), 32'd0); fin();
        jump_a = 1'b0;
        wait_vld(1'b0, 3, ok);
        chk("bb_latency", 32'(ok), 32'd1);
        if (ok) begin chk("bb_pc", pc_a, 32'h400); fin(); end
        repeat (3) step();

        // Random SRAM back-pressure: request must hold, delivered stream stays +4
        n0 = n_deliv;
        for (int i = 0; i < 200; i++) begin
            ready_a = 1'($urandom_range(0, 1));
            step();
        end
        ready_a = 1'b1;
        chk("rand_progress", 32'(n_deliv - n0 > 20), 32'd1);
        repeat (3) step();

        // PC wrap through 0xFFFF_FFFC
        jump_a = 1'b1; jaddr_a = 32'hFFFF_FFF8; sb_restart(32'hFFFF_FFF8);
        step();
        jump_a = 1'b0;
        seen_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            half();
            if (vld_a && pc_a == 32'h0) seen_wrap = 1'b1;
            fin();
        end
        chk("pc_wrap", 32'(seen_wrap), 32'd1);

        // Reset with a read in flight, then a stray rvalid right after reset
        rst_b = 1'b0;
        repeat (5) step();
        half(); chk("b_stream_vld", 32'(vld_b), 32'd1); fin();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0; inj_b = 1'b1;
        half();
        chk("b_post_vld", 32'(vld_b), 32'd0);
        chk("b_post_pc", pc_b, 32'h80);
        chk("b_post_req", 32'(ifb.req), 32'd1);
        chk("b_post_addr", ifb.addr, 32'h80);
        fin();
        inj_b = 1'b0;
        wait_vld(1'b1, 3, ok);
        chk("b_latency", 32'(ok), 32'd1);
        if (ok) begin
            chk("b_first_pc", pc_b, 32'h80);
            chk("b_first_instr", instr_b, 32'h20);
            fin();
            half();
            chk("b_second_vld", 32'(vld_b), 32'd1);
            chk("b_second_pc", pc_b, 32'h84);
            chk("b_second_instr", instr_b, 32'h21);
            fin();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
